// File: rtl/serial_unpacker.sv
// Receive side of the one-bit serial framing: start bit, WIDTH data bits, optional parity,
// presented on a valid/ready word port with a sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for a start bit (rx_bit=0) on a qualified cycle
// DATA  | shifting in WIDTH data bits
// PAR   | waiting for the parity bit
// HOLD  | word presented, waiting for out_ready
module serial_unpacker #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int PARITY    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic             rx_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit HAS_PARITY = (PARITY != 0);

    typedef enum logic [1:0] {IDLE, DATA, PAR, HOLD} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic             perr_calc;
    logic             start_bit;

    assign start_bit = rx_valid && !rx_bit;
    assign busy      = (state != IDLE);

    generate
        if (WIDTH == 1) begin : g_one_bit
            assign shift_next = rx_bit;
        end else if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_next = {shift[WIDTH-2:0], rx_bit};
        end else begin : g_lsb_first
            assign shift_next = {rx_bit, shift[WIDTH-1:1]};
        end
    endgenerate

    // In PAR the shift register already holds the complete word.
    generate
        if (PARITY == 0) begin : g_no_parity
            assign perr_calc = 1'b0;
        end else if (PARITY == 1) begin : g_even_parity
            assign perr_calc = (^shift) ^ rx_bit;
        end else begin : g_odd_parity
            assign perr_calc = ~((^shift) ^ rx_bit);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            shift     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_bit) begin
                        state <= DATA;
                        count <= '0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        shift <= shift_next;
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            if (HAS_PARITY) begin
                                state <= PAR;
                            end else begin
                                state     <= HOLD;
                                out_data  <= shift_next;
                                out_valid <= 1'b1;
                                out_perr  <= 1'b0;
                            end
                        end
                    end
                end
                PAR: begin
                    if (rx_valid) begin
                        state     <= HOLD;
                        out_data  <= shift;
                        out_valid <= 1'b1;
                        out_perr  <= perr_calc;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_perr  <= 1'b0;
                        // A start bit coinciding with acceptance begins the next frame.
                        if (start_bit) begin
                            state <= DATA;
                            count <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start_bit) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
